// File: rtl/game_ctrl_if.sv
// Bird/pipe position bus between the position generator (master) and the
// game controller (slave); carries positions one way and control/score back.
interface game_ctrl_if;
  logic [9:0]  birdy;
  logic [9:0]  upx1;
  logic [9:0]  upx2;
  logic [9:0]  upy1;
  logic [9:0]  upy2;
  logic        start;
  logic        fail;
  logic [11:0] score;
  logic [11:0] best;
  logic [1:0]  state;

  modport master (
    output birdy, upx1, upx2, upy1, upy2,
    input  start, fail, score, best, state
  );

  modport slave (
    input  birdy, upx1, upx2, upy1, upy2,
    output start, fail, score, best, state
  );
endinterface

// File: rtl/game_ctrl.sv
// Game control and judging: key handling, collision confirm, BCD score/best,
// and the start/fail levels that run, freeze or reload the position generator.
module game_ctrl #(
  parameter int BIRD_X      = 280,
  parameter int BIRD_W      = 34,
  parameter int BIRD_H      = 24,
  parameter int PIPE_W      = 52,
  parameter int UP_LEN      = 150,
  parameter int DN_OFS      = 250,
  parameter int GROUND_Y    = 400,
  parameter int HIT_CONFIRM = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key,
  game_ctrl_if.slave  pos
);
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    DEAD = 2'b10
  } state_t;

  localparam logic [10:0] BX_L = 11'(BIRD_X);
  localparam logic [10:0] BX_R = 11'(BIRD_X + BIRD_W);
  localparam logic [10:0] BH   = 11'(BIRD_H);
  localparam logic [10:0] PW   = 11'(PIPE_W);
  localparam logic [10:0] UL   = 11'(UP_LEN);
  localparam logic [10:0] DO   = 11'(DN_OFS);
  localparam logic [10:0] GY   = 11'(GROUND_Y);
  localparam logic [2:0]  HC   = 3'(HIT_CONFIRM);

  state_t      state_reg, state_next;
  logic        start_reg, start_next;
  logic        fail_reg, fail_next;
  logic [11:0] score_reg, score_next;
  logic [11:0] best_reg, best_next;
  logic [2:0]  hit_cnt_reg, hit_cnt_next;
  logic        key_meta_reg, key_s1_reg, key_s2_reg;
  logic        kpress;
  logic [9:0]  upx [2];
  logic [9:0]  upy [2];
  logic [1:0]  overlap;
  logic [1:0]  wrap;
  logic [10:0] bird_top, bird_bot;
  logic        hit_now, hit_confirm;
  logic [11:0] score_inc1, score_inc;

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v != 12'h999) begin
      if (v[3:0] == 4'd9) begin
        r[3:0] = 4'd0;
        if (v[7:4] == 4'd9) begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end else begin
          r[7:4] = v[7:4] + 4'd1;
        end
      end else begin
        r[3:0] = v[3:0] + 4'd1;
      end
    end
    return r;
  endfunction

  assign upx[0]   = pos.upx1;
  assign upx[1]   = pos.upx2;
  assign upy[0]   = pos.upy1;
  assign upy[1]   = pos.upy2;
  assign bird_top = {1'b0, pos.birdy};
  assign bird_bot = bird_top + BH;

  // Per-pipe overlap and wrap detection; 11-bit sums so nothing wraps.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pipe
      logic [9:0]  prev_x_reg;
      logic [10:0] px, py;
      logic        h, v;

      assign px = {1'b0, upx[gi]};
      assign py = {1'b0, upy[gi]};
      assign h  = (BX_R > px) && (BX_L < px + PW);
      assign v  = (bird_top < py + UL) || (bird_bot > py + DO);
      assign overlap[gi] = h && v;
      assign wrap[gi]    = (state_reg == PLAY) && (upx[gi] > prev_x_reg);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev_x_reg <= '0;
        else      prev_x_reg <= upx[gi];
      end
    end
  endgenerate

  assign hit_now    = (|overlap) || (bird_bot >= GY);
  assign kpress     = key_s1_reg & ~key_s2_reg;
  assign score_inc1 = wrap[0] ? bcd_inc(score_reg) : score_reg;
  assign score_inc  = wrap[1] ? bcd_inc(score_inc1) : score_inc1;

  always_comb begin
    hit_cnt_next = '0;
    if (state_reg == PLAY && hit_now)
      hit_cnt_next = (hit_cnt_reg >= HC) ? HC : hit_cnt_reg + 3'd1;
  end

  // Confirm on the edge where the counter reaches the threshold.
  assign hit_confirm = (state_reg == PLAY) && hit_now && (hit_cnt_next == HC);

  always_comb begin
    state_next = state_reg;
    score_next = score_reg;
    best_next  = best_reg;
    case (state_reg)
      IDLE: begin
        if (kpress) begin
          state_next = PLAY;
          score_next = '0;
        end
      end
      PLAY: begin
        score_next = score_inc;
        if (hit_confirm) begin
          state_next = DEAD;
          if (score_inc > best_reg) best_next = score_inc;
        end
      end
      DEAD: begin
        if (kpress) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    start_next = (state_next == PLAY);
    fail_next  = (state_next == DEAD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      start_reg    <= 1'b0;
      fail_reg     <= 1'b0;
      score_reg    <= '0;
      best_reg     <= '0;
      hit_cnt_reg  <= '0;
      key_meta_reg <= 1'b0;
      key_s1_reg   <= 1'b0;
      key_s2_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      start_reg    <= start_next;
      fail_reg     <= fail_next;
      score_reg    <= score_next;
      best_reg     <= best_next;
      hit_cnt_reg  <= hit_cnt_next;
      key_meta_reg <= key;
      key_s1_reg   <= key_meta_reg;
      key_s2_reg   <= key_s1_reg;
    end
  end

  assign pos.start = start_reg;
  assign pos.fail  = fail_reg;
  assign pos.score = score_reg;
  assign pos.best  = best_reg;
  assign pos.state = state_reg;
endmodule
